dct8_transpose_buf: RTL



---
 rtl/dct_pkg.sv | 10 +
 rtl/dct8_tp_bank.sv | 28 ++
 rtl/dct8_transpose_buf.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared types for the 2-D DCT transpose path.
package dct_pkg;

    localparam int DCT_N = 8;
    localparam int DCT_W = 16;

    typedef logic signed [DCT_W-1:0] coef_t;
    typedef coef_t vec_t [DCT_N];

endpackage

// File: rtl/dct8_tp_bank.sv
// One 8x8 coefficient bank: row-wide write port, column-wide read mux.
module dct8_tp_bank
    import dct_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [2:0] row,
    input  vec_t       wdata,
    input  logic [2:0] col,
    output vec_t       rdata
);

    // Storage is deliberately unreset; the control flags gate all reads.
    vec_t mem [DCT_N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[row] <= wdata;
        end
    end

    always_comb begin
        for (int k = 0; k < DCT_N; k++) begin
            rdata[k] = mem[k][col];
        end
    end

endmodule

// File: rtl/dct8_transpose_buf.sv
// Ping-pong 8x8 transpose between DCT row and column passes.
// Optional out_last framing port enabled by DCT_TP_LAST_EN.
module dct8_transpose_buf
    import dct_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    input  logic [DATA_W-1:0] in5,
    input  logic [DATA_W-1:0] in6,
    input  logic [DATA_W-1:0] in7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic [DATA_W-1:0] out6,
    output logic [DATA_W-1:0] out7
`ifdef DCT_TP_LAST_EN
    ,
    output logic              out_last
`endif
);

    generate
        if (N != DCT_N || DATA_W != DCT_W) begin : g_bad_cfg
            $error("dct8_transpose_buf: only N=8, DATA_W=16 supported");
        end
    endgenerate

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wr_sel;
    logic       rd_sel;
    logic [2:0] wr_row;
    logic [2:0] rd_col;
    logic       in_fire;
    logic       out_fire;
    vec_t       wvec;
    vec_t       rvec [2];
    vec_t       rsel;

    assign in_ready  = !full[wr_sel];
    assign out_valid = full[rd_sel];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

`ifdef DCT_TP_LAST_EN
    assign out_last = out_valid && (rd_col == 3'd7);
`endif

    always_comb begin
        wvec[0] = in0;
        wvec[1] = in1;
        wvec[2] = in2;
        wvec[3] = in3;
        wvec[4] = in4;
        wvec[5] = in5;
        wvec[6] = in6;
        wvec[7] = in7;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct8_tp_bank u_bank (
            .clk   (clk),
            .we    (in_fire && (wr_sel == 1'(b))),
            .row   (wr_row),
            .wdata (wvec),
            .col   (rd_col),
            .rdata (rvec[b])
        );
    end

    // Outputs read as zero whenever no column is being offered.
    always_comb begin
        rsel = rvec[rd_sel];
        out0 = out_valid ? rsel[0] : '0;
        out1 = out_valid ? rsel[1] : '0;
        out2 = out_valid ? rsel[2] : '0;
        out3 = out_valid ? rsel[3] : '0;
        out4 = out_valid ? rsel[4] : '0;
        out5 = out_valid ? rsel[5] : '0;
        out6 = out_valid ? rsel[6] : '0;
        out7 = out_valid ? rsel[7] : '0;
    end

    // Fill and drain always target different banks, so both may apply.
    always_comb begin
        full_nxt = full;
        if (in_fire && wr_row == 3'd7) begin
            full_nxt[wr_sel] = 1'b1;
        end
        if (out_fire && rd_col == 3'd7) begin
            full_nxt[rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 2'b00;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_row <= 3'd0;
            rd_col <= 3'd0;
        end else begin
            full <= full_nxt;
            if (in_fire) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    wr_sel <= !wr_sel;
                end
            end
            if (out_fire) begin
                rd_col <= rd_col + 3'd1;
                if (rd_col == 3'd7) begin
                    rd_sel <= !rd_sel;
                end
            end
        end
    end

endmodule
